// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler: FSM state encoding and the ALU
// opcode numbering used by both the scheduler and its ALU.
package alu_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Opcode 2 is intentionally unassigned and produces a zero result.
   localparam int OP_ADD   = 0;
   localparam int OP_SUB   = 1;
   localparam int OP_SLL   = 3;
   localparam int OP_SRL   = 4;
   localparam int OP_SRA   = 5;
   localparam int OP_SLTU  = 6;
   localparam int OP_SLT   = 7;
   localparam int OP_OR    = 8;
   localparam int OP_AND   = 9;
   localparam int OP_XOR   = 10;
   localparam int OP_UPPER = 11;

   // Bit position where an upper-immediate operand is placed.
   localparam int UPPER_SHIFT = 12;

endpackage

// File: rtl/alu_scheduler_alu.sv
// Purely combinational ALU.
// Ports:
//   a, b  : operands (WORDSIZE)
//   op    : opcode (OPSIZE), encoding from alu_scheduler_pkg
//   r     : result (WORDSIZE); zero for undefined opcodes
module alu_scheduler_alu
   import alu_scheduler_pkg::*;
#(
   parameter int WORDSIZE = 32,
   parameter int OPSIZE   = 32
) (
   input  logic [WORDSIZE-1:0] a,
   input  logic [WORDSIZE-1:0] b,
   input  logic [OPSIZE-1:0]   op,
   output logic [WORDSIZE-1:0] r
);

   localparam int SHW = $clog2(WORDSIZE);

   // Shift amounts come from the low bits of b only.
   logic [SHW-1:0] sh;
   assign sh = b[SHW-1:0];

   always_comb begin
      r = '0;
      case (op)
         OPSIZE'(OP_ADD):   r = a + b;
         OPSIZE'(OP_SUB):   r = a - b;
         OPSIZE'(OP_SLL):   r = a << sh;
         OPSIZE'(OP_SRL):   r = a >> sh;
         OPSIZE'(OP_SRA):   r = $unsigned($signed(a) >>> sh);
         OPSIZE'(OP_SLTU):  r = {{(WORDSIZE-1){1'b0}}, (a < b)};
         OPSIZE'(OP_SLT):   r = {{(WORDSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
         OPSIZE'(OP_OR):    r = a | b;
         OPSIZE'(OP_AND):   r = a & b;
         OPSIZE'(OP_XOR):   r = a ^ b;
         OPSIZE'(OP_UPPER): r = b << UPPER_SHIFT;
         default:           r = '0;
      endcase
   end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester scheduler sharing a single ALU.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting; grants one valid requester and latches its operands
//   ST_EXEC | ALU evaluates latched operands; result registered to RSP_R
//   ST_RESP | response held on RSP_* until RSP_READY
//
// Ports:
//   CLK, RST                       : clock, async active-high reset
//   REQx_VALID/A/B/OP, REQx_READY  : requester x (x = 0,1); READY is the
//                                    combinational accept strobe in IDLE
//   RSP_VALID/R/ID, RSP_READY      : response channel
//   BUSY                           : high whenever not in IDLE
module alu_scheduler
   import alu_scheduler_pkg::*;
#(
   parameter int WORDSIZE = 32,
   parameter int OPSIZE   = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                REQ0_VALID,
   input  logic [WORDSIZE-1:0] REQ0_A,
   input  logic [WORDSIZE-1:0] REQ0_B,
   input  logic [OPSIZE-1:0]   REQ0_OP,
   output logic                REQ0_READY,
   input  logic                REQ1_VALID,
   input  logic [WORDSIZE-1:0] REQ1_A,
   input  logic [WORDSIZE-1:0] REQ1_B,
   input  logic [OPSIZE-1:0]   REQ1_OP,
   output logic                REQ1_READY,
   output logic                RSP_VALID,
   input  logic                RSP_READY,
   output logic [WORDSIZE-1:0] RSP_R,
   output logic                RSP_ID,
   output logic                BUSY
);

   state_e              state_q, state_d;
   logic                last_q, last_d;
   logic                id_q, id_d;
   logic [WORDSIZE-1:0] a_q, a_d;
   logic [WORDSIZE-1:0] b_q, b_d;
   logic [OPSIZE-1:0]   op_q, op_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [WORDSIZE-1:0] rsp_r_q, rsp_r_d;
   logic                rsp_id_q, rsp_id_d;

   logic                any_valid;
   logic                grant_id;
   logic                accept;
   logic [WORDSIZE-1:0] alu_r;

   // On a tie the requester that did not win last time is served.
   assign any_valid = REQ0_VALID | REQ1_VALID;
   assign grant_id  = (REQ0_VALID && REQ1_VALID) ? ~last_q : REQ1_VALID;
   // READY must stay low while reset is asserted even though state is IDLE.
   assign accept    = (state_q == ST_IDLE) && !RST && any_valid;

   alu_scheduler_alu #(
      .WORDSIZE (WORDSIZE),
      .OPSIZE   (OPSIZE)
   ) u_alu (
      .a  (a_q),
      .b  (b_q),
      .op (op_q),
      .r  (alu_r)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_q      <= 1'b1;
         id_q        <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_r_q     <= '0;
         rsp_id_q    <= 1'b0;
      end else begin
         last_q      <= last_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_r_q     <= rsp_r_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_valid) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (RSP_READY) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      REQ0_READY  = 1'b0;
      REQ1_READY  = 1'b0;
      last_d      = last_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_r_d     = rsp_r_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               REQ0_READY = ~grant_id;
               REQ1_READY = grant_id;
               last_d     = grant_id;
               id_d       = grant_id;
               a_d        = grant_id ? REQ1_A  : REQ0_A;
               b_d        = grant_id ? REQ1_B  : REQ0_B;
               op_d       = grant_id ? REQ1_OP : REQ0_OP;
            end
         end
         ST_EXEC: begin
            rsp_valid_d = 1'b1;
            rsp_r_d     = alu_r;
            rsp_id_d    = id_q;
         end
         ST_RESP: begin
            if (RSP_READY) rsp_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign RSP_VALID = rsp_valid_q;
   assign RSP_R     = rsp_r_q;
   assign RSP_ID    = rsp_id_q;
   assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
module tb_alu_scheduler;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        REQ0_VALID = 1'b0;
   logic [31:0] REQ0_A = '0, REQ0_B = '0, REQ0_OP = '0;
   logic        REQ0_READY;
   logic        REQ1_VALID = 1'b0;
   logic [31:0] REQ1_A = '0, REQ1_B = '0, REQ1_OP = '0;
   logic        REQ1_READY;
   logic        RSP_VALID;
   logic        RSP_READY = 1'b0;
   logic [31:0] RSP_R;
   logic        RSP_ID;
   logic        BUSY;

   int errors = 0;
   int checks = 0;
   bit model_last = 1'b1;

   alu_scheduler #(.WORDSIZE(32), .OPSIZE(32)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_OP(REQ0_OP), .REQ0_READY(REQ0_READY),
      .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_OP(REQ1_OP), .REQ1_READY(REQ1_READY),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_R(RSP_R), .RSP_ID(RSP_ID), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // Reference ALU written from the opcode table with plain arithmetic.
   function automatic logic [31:0] ref_alu(logic [31:0] op, logic [31:0] a, logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         32'd0:   return a + b;
         32'd1:   return a - b;
         32'd3:   return a << sh;
         32'd4:   return a >> sh;
         32'd5:   return $unsigned($signed(a) >>> sh);
         32'd6:   return (a < b) ? 32'd1 : 32'd0;
         32'd7:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         32'd8:   return a | b;
         32'd9:   return a & b;
         32'd10:  return a ^ b;
         32'd11:  return b << 12;
         default: return 32'd0;
      endcase
   endfunction

   // Issues one operation from a single requester, scrambles its inputs after
   // acceptance, waits for the response and acknowledges it.
   task automatic run_one(input bit id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] op, output bit rdy_ok, output int lat,
                          output logic [31:0] r, output logic rid);
      @(negedge CLK);
      if (id) begin REQ1_VALID = 1; REQ1_A = a; REQ1_B = b; REQ1_OP = op; end
      else    begin REQ0_VALID = 1; REQ0_A = a; REQ0_B = b; REQ0_OP = op; end
      #1;
      rdy_ok = id ? (REQ1_READY && !REQ0_READY) : (REQ0_READY && !REQ1_READY);
      @(negedge CLK);
      REQ0_VALID = 0; REQ1_VALID = 0;
      REQ0_A = $urandom; REQ0_B = $urandom; REQ1_A = $urandom; REQ1_B = $urandom;
      #1;
      lat = 1;
      while (!RSP_VALID && lat < 10) begin
         @(negedge CLK); #1; lat++;
      end
      r = RSP_R; rid = RSP_ID;
      RSP_READY = 1;
      @(negedge CLK);
      RSP_READY = 0;
      model_last = id;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      REQ0_VALID = 1; REQ1_VALID = 1;
      #1;
      checks++;
      if (REQ0_READY !== 0 || REQ1_READY !== 0 || RSP_VALID !== 0 || RSP_R !== 0 ||
          RSP_ID !== 0 || BUSY !== 0)
         begin errors++; $display("FAIL reset_outputs: r0=%b r1=%b v=%b r=%h id=%b busy=%b, required all 0",
                                  REQ0_READY, REQ1_READY, RSP_VALID, RSP_R, RSP_ID, BUSY); end
      REQ0_VALID = 0; REQ1_VALID = 0;
      @(negedge CLK);
      RST = 0;
      model_last = 1;
   endtask

   task automatic test_single();
      @(negedge CLK);
      REQ0_VALID = 1; REQ0_A = 5; REQ0_B = 3; REQ0_OP = 0;
      #1;
      checks++;
      if (REQ0_READY !== 1 || REQ1_READY !== 0)
         begin errors++; $display("FAIL single_ready: r0=%b r1=%b, required 1 0", REQ0_READY, REQ1_READY); end
      @(negedge CLK);
      REQ0_VALID = 0;
      #1;
      checks++;
      if (RSP_VALID !== 0 || BUSY !== 1)
         begin errors++; $display("FAIL single_exec: valid=%b busy=%b, required 0 1", RSP_VALID, BUSY); end
      @(negedge CLK); #1;
      checks++;
      if (RSP_VALID !== 1 || RSP_R !== 32'd8 || RSP_ID !== 0)
         begin errors++; $display("FAIL single_rsp: valid=%b r=%0d id=%b, required 1 8 0", RSP_VALID, RSP_R, RSP_ID); end
      RSP_READY = 1;
      @(negedge CLK);
      RSP_READY = 0;
      #1;
      checks++;
      if (RSP_VALID !== 0 || BUSY !== 0)
         begin errors++; $display("FAIL single_ack: valid=%b busy=%b, required 0 0", RSP_VALID, BUSY); end
      model_last = 0;
   endtask

   task automatic test_tie_after_reset();
      logic [31:0] r;
      logic        rid;
      int          lat;
      // Fresh reset so LAST starts at 1.
      @(negedge CLK); RST = 1; @(negedge CLK); RST = 0; model_last = 1;
      REQ0_VALID = 1; REQ0_A = 10;    REQ0_B = 4;    REQ0_OP = 1;
      REQ1_VALID = 1; REQ1_A = 32'hF0; REQ1_B = 32'h3C; REQ1_OP = 9;
      for (int g = 0; g < 2; g++) begin
         #1;
         checks++;
         if (REQ0_READY !== (g == 0) || REQ1_READY !== (g == 1))
            begin errors++; $display("FAIL tie_grant%0d: r0=%b r1=%b, required %b %b", g, REQ0_READY, REQ1_READY, g == 0, g == 1); end
         @(negedge CLK);
         lat = 1; #1;
         while (!RSP_VALID && lat < 10) begin @(negedge CLK); #1; lat++; end
         r = RSP_R; rid = RSP_ID;
         checks++;
         if (lat != 2 || r !== ((g == 0) ? 32'd6 : 32'h30) || rid !== 1'(g))
            begin errors++; $display("FAIL tie_rsp%0d: lat=%0d r=%h id=%b, required 2 %h %0d", g, lat, r, rid, (g == 0) ? 32'd6 : 32'h30, g); end
         RSP_READY = 1;
         @(negedge CLK);
         RSP_READY = 0;
      end
      REQ0_VALID = 0; REQ1_VALID = 0;
      model_last = 1;
   endtask

   task automatic test_backpressure();
      logic [31:0] r0;
      logic        id0;
      int          bad;
      @(negedge CLK);
      REQ0_VALID = 1; REQ0_A = 32'd100; REQ0_B = 32'd23; REQ0_OP = 1;
      #1;
      @(negedge CLK);
      REQ0_VALID = 1; REQ1_VALID = 1;   // keep both asking; nothing may be accepted
      @(negedge CLK); #1;
      r0 = RSP_R; id0 = RSP_ID;
      checks++;
      if (RSP_VALID !== 1 || r0 !== 32'd77 || id0 !== 0)
         begin errors++; $display("FAIL bp_first: valid=%b r=%0d id=%b, required 1 77 0", RSP_VALID, r0, id0); end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK); #1;
         if (RSP_VALID !== 1 || RSP_R !== r0 || RSP_ID !== id0 || REQ0_READY !== 0 ||
             REQ1_READY !== 0 || BUSY !== 1) bad++;
      end
      checks++;
      if (bad != 0)
         begin errors++; $display("FAIL bp_hold: unstable cycles=%0d, required 0", bad); end
      REQ0_VALID = 0; REQ1_VALID = 0;
      RSP_READY = 1;
      @(negedge CLK);
      RSP_READY = 0;
      #1;
      checks++;
      if (RSP_VALID !== 0 || BUSY !== 0)
         begin errors++; $display("FAIL bp_release: valid=%b busy=%b, required 0 0", RSP_VALID, BUSY); end
      model_last = 0;
   endtask

   task automatic test_compare_invalid();
      logic [31:0] ops[3] = '{32'd7, 32'd6, 32'd2};
      logic [31:0] exp[3] = '{32'd1, 32'd0, 32'd0};
      bit          rdy;
      int          lat;
      logic [31:0] r;
      logic        rid;
      for (int i = 0; i < 3; i++) begin
         run_one(1'b1, 32'hFFFF_FFFF, 32'd1, ops[i], rdy, lat, r, rid);
         checks++;
         if (!rdy || lat != 2 || r !== exp[i] || rid !== 1)
            begin errors++; $display("FAIL cmp_op%0d: rdy=%b lat=%0d r=%h id=%b, required 1 2 %h 1", ops[i], rdy, lat, r, rid, exp[i]); end
      end
   endtask

   task automatic test_reset_in_exec();
      int seen;
      @(negedge CLK);
      REQ0_VALID = 1; REQ0_A = 32'd9; REQ0_B = 32'd9; REQ0_OP = 0;
      @(negedge CLK);
      REQ0_VALID = 0;
      RST = 1;
      #1;
      checks++;
      if (RSP_VALID !== 0 || RSP_R !== 0 || RSP_ID !== 0 || BUSY !== 0 ||
          REQ0_READY !== 0 || REQ1_READY !== 0)
         begin errors++; $display("FAIL rst_exec_outputs: v=%b r=%h id=%b busy=%b, required all 0", RSP_VALID, RSP_R, RSP_ID, BUSY); end
      @(negedge CLK);
      RST = 0;
      model_last = 1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK); #1;
         if (RSP_VALID !== 0 || BUSY !== 0) seen++;
      end
      checks++;
      if (seen != 0)
         begin errors++; $display("FAIL rst_exec_no_rsp: cycles with activity=%0d, required 0", seen); end
      @(negedge CLK);
      REQ0_VALID = 1; REQ0_OP = 0; REQ0_A = 1; REQ0_B = 2;
      REQ1_VALID = 1; REQ1_OP = 0; REQ1_A = 3; REQ1_B = 4;
      #1;
      checks++;
      if (REQ0_READY !== 1 || REQ1_READY !== 0)
         begin errors++; $display("FAIL rst_exec_tie: r0=%b r1=%b, required 1 0", REQ0_READY, REQ1_READY); end
      @(negedge CLK);
      REQ0_VALID = 0; REQ1_VALID = 0;
      @(negedge CLK); #1;
      checks++;
      if (RSP_VALID !== 1 || RSP_R !== 32'd3 || RSP_ID !== 0)
         begin errors++; $display("FAIL rst_exec_after: v=%b r=%0d id=%b, required 1 3 0", RSP_VALID, RSP_R, RSP_ID); end
      RSP_READY = 1;
      @(negedge CLK);
      RSP_READY = 0;
      model_last = 0;
   endtask

   task automatic test_operand_stability();
      int lat;
      @(negedge CLK);
      REQ1_VALID = 1; REQ1_A = 32'd1; REQ1_B = 32'd4; REQ1_OP = 3;
      #1;
      checks++;
      if (REQ1_READY !== 1 || REQ0_READY !== 0)
         begin errors++; $display("FAIL stab_ready: r0=%b r1=%b, required 0 1", REQ0_READY, REQ1_READY); end
      @(negedge CLK);
      REQ1_VALID = 0; REQ1_A = 32'd7;
      lat = 1; #1;
      while (!RSP_VALID && lat < 10) begin @(negedge CLK); #1; lat++; end
      checks++;
      if (lat != 2 || RSP_R !== 32'd16 || RSP_ID !== 1)
         begin errors++; $display("FAIL stab_rsp: lat=%0d r=%0d id=%b, required 2 16 1", lat, RSP_R, RSP_ID); end
      RSP_READY = 1;
      @(negedge CLK);
      RSP_READY = 0;
      model_last = 1;
   endtask

   task automatic test_random();
      bit          v0, v1, g;
      logic [31:0] exp_r, r_hold;
      int          lat, hold, bad_ready, bad_hold;
      for (int it = 0; it < 60; it++) begin
         @(negedge CLK);
         v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
         REQ0_VALID = v0; REQ1_VALID = v1;
         REQ0_A = $urandom; REQ0_B = $urandom; REQ1_A = $urandom; REQ1_B = $urandom;
         REQ0_OP = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12));
         REQ1_OP = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12));
         #1;
         if (!v0 && !v1) begin
            checks++;
            if (REQ0_READY !== 0 || REQ1_READY !== 0 || BUSY !== 0)
               begin errors++; $display("FAIL rnd_idle%0d: r0=%b r1=%b busy=%b, required 0 0 0", it, REQ0_READY, REQ1_READY, BUSY); end
            continue;
         end
         g = (v0 && v1) ? ~model_last : v1;
         checks++;
         if (REQ0_READY !== !g || REQ1_READY !== g)
            begin errors++; $display("FAIL rnd_grant%0d: r0=%b r1=%b, required %b %b", it, REQ0_READY, REQ1_READY, !g, g); end
         model_last = g;
         exp_r = g ? ref_alu(REQ1_OP, REQ1_A, REQ1_B) : ref_alu(REQ0_OP, REQ0_A, REQ0_B);
         @(negedge CLK);
         // Scramble everything the scheduler should now ignore.
         REQ0_VALID = 1'($urandom_range(0, 1)); REQ1_VALID = 1'($urandom_range(0, 1));
         REQ0_A = $urandom; REQ0_B = $urandom; REQ0_OP = $urandom;
         REQ1_A = $urandom; REQ1_B = $urandom; REQ1_OP = $urandom;
         RSP_READY = 1'($urandom_range(0, 1));
         lat = 1; bad_ready = 0; #1;
         if (REQ0_READY !== 0 || REQ1_READY !== 0) bad_ready++;
         while (!RSP_VALID && lat < 10) begin
            @(negedge CLK); #1; lat++;
            if (REQ0_READY !== 0 || REQ1_READY !== 0) bad_ready++;
         end
         RSP_READY = 0;
         checks++;
         if (lat != 2 || RSP_R !== exp_r || RSP_ID !== g || bad_ready != 0)
            begin errors++; $display("FAIL rnd_rsp%0d: lat=%0d r=%h id=%b stray_ready=%0d, required 2 %h %b 0", it, lat, RSP_R, RSP_ID, bad_ready, exp_r, g); end
         r_hold = RSP_R;
         hold = $urandom_range(0, 3);
         bad_hold = 0;
         for (int h = 0; h < hold; h++) begin
            @(negedge CLK); #1;
            if (RSP_VALID !== 1 || RSP_R !== r_hold || RSP_ID !== g ||
                REQ0_READY !== 0 || REQ1_READY !== 0) bad_hold++;
         end
         checks++;
         if (bad_hold != 0)
            begin errors++; $display("FAIL rnd_hold%0d: unstable cycles=%0d, required 0", it, bad_hold); end
         RSP_READY = 1;
         @(negedge CLK);
         RSP_READY = 0; REQ0_VALID = 0; REQ1_VALID = 0;
         #1;
         checks++;
         if (RSP_VALID !== 0 || BUSY !== 0)
            begin errors++; $display("FAIL rnd_ack%0d: valid=%b busy=%b, required 0 0", it, RSP_VALID, BUSY); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie_after_reset();
      test_backpressure();
      test_compare_invalid();
      test_reset_in_exec();
      test_operand_stability();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
